// File: rtl/fp_11_4_pkg.sv
// FP_11_4 word format shared by the fixed-to-float converter and the
// FP subtract/compare users: {exc[1:0], sign, exp[10:0], frac[3:0]}.
package fp_11_4_pkg;

  localparam int WE   = 11;
  localparam int WF   = 4;
  localparam int BIAS = 1023;
  localparam int FP_W = 2 + 1 + WE + WF;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;

  // Field bit positions inside the 18-bit word
  localparam int EXC_HI   = 17;
  localparam int EXC_LO   = 16;
  localparam int SIGN_POS = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 4;
  localparam int FRAC_HI  = 3;
  localparam int FRAC_LO  = 0;

  typedef logic [FP_W-1:0] fp_word_t;

  // Assemble a word from its fields
  function automatic fp_word_t fp_pack(input logic [1:0]    exc,
                                       input logic          sign,
                                       input logic [WE-1:0] exp_f,
                                       input logic [WF-1:0] frac_f);
    fp_word_t w;
    w                   = '0;
    w[EXC_HI:EXC_LO]    = exc;
    w[SIGN_POS]         = sign;
    w[EXP_HI:EXP_LO]    = exp_f;
    w[FRAC_HI:FRAC_LO]  = frac_f;
    return w;
  endfunction

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter. count = W when the input is all zeros,
// and zero flags that case explicitly.
module lzc_count #(
  parameter int W = 16
) (
  input  logic [W-1:0]             d,
  output logic [$clog2(W+1)-1:0]   count,
  output logic                     zero
);

  localparam int CW = $clog2(W + 1);

  // Priority scan from LSB upward so the highest set bit has the last word
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a path
    // that never hits a set bit would leave count unassigned and infer a latch.
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) count = CW'(W - 1 - i);
    end
    zero = (d == '0);
  end

endmodule

// File: rtl/fix_to_fp_11_4.sv
// Streaming 3-stage signed fixed-point to FP_11_4 converter with a
// valid/ready handshake and full backpressure.
//   S1: sign and magnitude
//   S2: normalise (leading-zero count, shift out hidden one, guard/sticky)
//   S3: round (or truncate) and pack; S3 register drives out_valid/out_data
// Build option: define FIX2FP_ROUND_EN for round-to-nearest-even; when it is
// undefined the fraction is truncated. Latency and handshake are unchanged.
module fix_to_fp_11_4
  import fp_11_4_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_data
);

  localparam int LW       = $clog2(IN_W + 1);
  localparam int NW       = IN_W + 6;            // magnitude plus frac/guard/sticky room
  localparam int EXP_BASE = BIAS + IN_W - 1 - FRAC_W;

  // Stage registers
  logic              s1_valid, s1_sign;
  logic [IN_W-1:0]   s1_mag;

  logic              s2_valid, s2_sign, s2_zero, s2_guard, s2_sticky;
  logic [WE-1:0]     s2_exp;
  logic [WF-1:0]     s2_frac;

  logic              s3_valid;

  // Ready chain, combinational from out_ready back to in_ready
  logic s1_load, s2_load, s3_load;

  assign s3_load   = !s3_valid || out_ready;
  assign s2_load   = !s2_valid || s3_load;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s3_valid;

  // ---------------- S1: sign / magnitude ----------------
  logic [IN_W-1:0] mag_d;

  // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1) exactly
  always_comb begin
    mag_d = in_data[IN_W-1] ? (~in_data) + IN_W'(1) : in_data;
  end

  // S1 register: valid is reset, payload only moves with a real word
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous stage's value from before this edge.
    // NOTE: only valids (and out_data) are reset; payload registers are
    // qualified by their valid bit, so clearing them would buy nothing.
    if (!rst)         s1_valid <= 1'b0;
    else if (s1_load) s1_valid <= in_valid;

    if (s1_load && in_valid) begin
      s1_sign <= in_data[IN_W-1];
      s1_mag  <= mag_d;
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LW-1:0]   lz;
  logic            mag_zero;
  logic [LW:0]     shamt;
  logic [NW-1:0]   norm;
  logic [WE-1:0]   exp_d;

  lzc_count #(.W(IN_W)) u_lzc (
    .d     (s1_mag),
    .count (lz),
    .zero  (mag_zero)
  );

  // Shift by L+1 so the leading one falls off the top; what remains is
  // frac, then guard, then sticky bits
  always_comb begin
    shamt = (LW + 1)'(lz) + (LW + 1)'(1);
    norm  = {s1_mag, 6'b0} << shamt;
    exp_d = WE'(EXP_BASE) - WE'(lz);
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (!rst)         s2_valid <= 1'b0;
    else if (s2_load) s2_valid <= s1_valid;

    if (s2_load && s1_valid) begin
      s2_sign   <= s1_sign;
      s2_zero   <= mag_zero;
      s2_exp    <= exp_d;
      s2_frac   <= norm[NW-1 -: WF];
      s2_guard  <= norm[NW-1-WF];
      s2_sticky <= |norm[NW-2-WF:0];
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [WF-1:0] frac_r;
  logic [WE-1:0] exp_r;
  fp_word_t      word_d;

`ifdef FIX2FP_ROUND_EN
  logic          rnd_inc;
  logic [WF:0]   frac_sum;

  // Round to nearest, ties to even; a fraction carry bumps the exponent
  always_comb begin
    rnd_inc  = s2_guard & (s2_sticky | s2_frac[0]);
    frac_sum = {1'b0, s2_frac} + (WF + 1)'(rnd_inc);
    frac_r   = frac_sum[WF-1:0];
    exp_r    = s2_exp + WE'(frac_sum[WF]);
  end
`else
  logic unused_rnd;

  // Truncation: guard and sticky are carried but not consumed
  always_comb begin
    frac_r     = s2_frac;
    exp_r      = s2_exp;
    unused_rnd = s2_guard ^ s2_sticky;
  end
`endif

  // Zero has its own encoding with a positive sign
  always_comb begin
    word_d = s2_zero ? fp_pack(EXC_ZERO, 1'b0, '0, '0)
                     : fp_pack(EXC_NORMAL, s2_sign, exp_r, frac_r);
  end

  // S3 / output register: held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      s3_valid <= 1'b0;
      out_data <= '0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) out_data <= word_d;
    end
  end

endmodule

// File: tb/tb_fix_to_fp_11_4.sv
// Self-checking bench for fix_to_fp_11_4 (IN_W = 16, FRAC_W = 8).
// Expected rounding results follow FIX2FP_ROUND_EN as the DUT is built.
module tb_fix_to_fp_11_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;

  int checks   = 0;
  int failures = 0;

  bit          sb_en = 1'b0;
  logic [17:0] sb_q[$];
  int          n_in  = 0;
  int          n_out = 0;

  fix_to_fp_11_4 #(.IN_W(16), .FRAC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Reference conversion written from the number's value, not the pipeline
  function automatic logic [17:0] model(input logic [15:0] d);
    int  m, p, e, fr, rem, half;
    logic s;
    if (d == 16'h0000) return 18'h0;
    s  = d[15];
    m  = s ? (65536 - int'(d)) : int'(d);
    p  = 15;
    while (((m >> p) & 1) == 0) p--;
    e  = 1023 + p - 8;
    if (p >= 4) begin
      fr   = (m >> (p - 4)) & 15;
      rem  = m & ((1 << (p - 4)) - 1);
      half = (p >= 5) ? (1 << (p - 5)) : 0;
    end else begin
      fr   = (m << (4 - p)) & 15;
      rem  = 0;
      half = 0;
    end
`ifdef FIX2FP_ROUND_EN
    if (half != 0 && (rem > half || (rem == half && (fr & 1) == 1))) begin
      fr++;
      if (fr == 16) begin
        fr = 0;
        e++;
      end
    end
`endif
    return {2'b01, s, 11'(e), 4'(fr)};
  endfunction

  task automatic settle();
    #1;
  endtask

  // Record transfers at the coming edge, then advance to just after it
  task automatic clock_edge(output bit took_in);
    took_in = in_valid && in_ready;
    if (sb_en && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_out", 32'(out_data), 32'h3ffff + 1);
      else check("sb_out", 32'(out_data), 32'(sb_q.pop_front()));
      n_out++;
    end
    if (sb_en && took_in) begin
      sb_q.push_back(model(in_data));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  // One word in an empty pipe: taken at the first edge, out after the third
  task automatic run_vec(input string name, input logic [15:0] din, input logic [17:0] want);
    bit t;
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    settle();
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    clock_edge(t);
    in_valid = 1'b0;
    settle();
    clock_edge(t);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    clock_edge(t);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(want));
    clock_edge(t);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [17:0] want_rne;
    logic [17:0] want_trc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit          t;
    int          sent;
    logic [17:0] held;
    logic [15:0] bp_words[8];

    vecs[0]  = '{16'h0100, 18'h13FF0, 18'h13FF0};  // +1.0
    vecs[1]  = '{16'hFD00, 18'h1C008, 18'h1C008};  // -3.0
    vecs[2]  = '{16'h0000, 18'h00000, 18'h00000};  // zero
    vecs[3]  = '{16'h0001, 18'h13F70, 18'h13F70};  // smallest positive
    vecs[4]  = '{16'h8000, 18'h1C060, 18'h1C060};  // most negative
    vecs[5]  = '{16'h0118, 18'h13FF2, 18'h13FF1};  // tie, odd -> up
    vecs[6]  = '{16'h01F8, 18'h14000, 18'h13FFF};  // tie with carry
    vecs[7]  = '{16'h0128, 18'h13FF2, 18'h13FF2};  // tie, even -> stay
    vecs[8]  = '{16'h0119, 18'h13FF2, 18'h13FF1};  // above half
    vecs[9]  = '{16'h7FFF, 18'h14060, 18'h1405F};  // largest positive
    vecs[10] = '{16'hFFFF, 18'h1BF70, 18'h1BF70};  // -2^-8
    vecs[11] = '{16'hFE80, 18'h1BFF8, 18'h1BFF8};  // -1.5

    bp_words = '{16'h0100, 16'hFD00, 16'h0118, 16'h01F8,
                 16'h0001, 16'h8000, 16'h7FFF, 16'h0000};

    // Reset state
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) clock_edge(t);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b1;
    settle();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
`ifdef FIX2FP_ROUND_EN
      run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].want_rne);
`else
      run_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].want_trc);
`endif
    end

    // Backpressure: 8 words, consumer stalls during cycles 4..9
    sb_en = 1'b1;
    n_in  = 0;
    n_out = 0;
    sent  = 0;
    held  = '0;
    for (int c = 0; c < 60 && (sent < 8 || sb_q.size() > 0); c++) begin
      in_valid  = (sent < 8);
      in_data   = bp_words[sent % 8];
      out_ready = !(c >= 4 && c <= 9);
      settle();
      if (c == 3) check("bp_full_flowing_ready", 32'(in_ready), 32'd1);
      if (c == 6) check("bp_stalled_ready", 32'(in_ready), 32'd0);
      if (c == 4) held = out_data;
      if (c >= 5 && c <= 9) begin
        check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("bp_hold_data_c%0d", c), 32'(out_data), 32'(held));
      end
      clock_edge(t);
      if (t) sent++;
    end
    check("bp_words_in", 32'(n_in), 32'd8);
    check("bp_words_out", 32'(n_out), 32'd8);
    sb_en = 1'b0;

    // Reset with 3 words in flight and the consumer stalled
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = bp_words[k + 1];
      settle();
      clock_edge(t);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    settle();
    clock_edge(t);
    rst       = 1'b1;
    out_ready = 1'b1;
    settle();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_vec("post_rst", 16'h0100, 18'h13FF0);

    // Random stream with random backpressure
    sb_en = 1'b1;
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 60000 && n_in < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       in_data = 16'h8000;
        1:       in_data = 16'h0000;
        2:       in_data = 16'(($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0001);
        default: in_data = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      settle();
      clock_edge(t);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb_q.size() > 0; k++) begin
      settle();
      clock_edge(t);
    end
    check("rand_words_in", 32'(n_in), 32'd10000);
    check("rand_drained", 32'(sb_q.size()), 32'd0);
    check("rand_in_eq_out", 32'(n_out), 32'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
